// File: rtl/cmp_sched_pkg.sv
// Shared types and defaults for the cmp_sched comparator scheduler.
package cmp_sched_pkg;

    localparam int unsigned DATA_W_DEF  = 16;
    localparam int unsigned NUM_REQ_DEF = 4;

    typedef enum logic {
        IDLE,
        CMP
    } cmp_state_t;

    typedef struct packed {
        logic gt;
        logic lt;
        logic eq;
    } cmp_res_t;

endpackage : cmp_sched_pkg

// File: rtl/cmp_sched_if.sv
// Requester-side bus of cmp_sched: per-lane requests/operands in, grant/done/result out.
// Optional macro CMP_SCHED_COUNT_EN adds the cmp_count result-counter signal.
interface cmp_sched_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 16
);
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] a_in;
    logic [NUM_REQ*DATA_W-1:0] b_in;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        done;
    logic                      busy;
    logic                      gt;
    logic                      lt;
    logic                      eq;
    logic [IDX_W-1:0]          result_id;
`ifdef CMP_SCHED_COUNT_EN
    logic [15:0]               cmp_count;
`endif

    // Requester side
    modport master (
        output req, a_in, b_in,
        input  grant, done, busy, gt, lt, eq, result_id
`ifdef CMP_SCHED_COUNT_EN
        , input cmp_count
`endif
    );

    // Scheduler side
    modport slave (
        input  req, a_in, b_in,
        output grant, done, busy, gt, lt, eq, result_id
`ifdef CMP_SCHED_COUNT_EN
        , output cmp_count
`endif
    );

endinterface : cmp_sched_if

// File: rtl/cmp_sched_mag_cmp.sv
// Shared unsigned magnitude comparator (combinational).
module mag_cmp
    import cmp_sched_pkg::*;
#(
    parameter int unsigned W = DATA_W_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output cmp_res_t     res_c
);

    // Exactly one of gt/lt/eq is set for any operand pair
    always_comb begin
        res_c    = '0;
        res_c.gt = (a > b);
        res_c.lt = (a < b);
        res_c.eq = (a == b);
    end

endmodule : mag_cmp

// File: rtl/cmp_sched_rr_arbiter.sv
// Combinational round-robin pick: first set req searching upward from rr_ptr+1, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant_next_c,
    output logic [IDX_W-1:0]   idx_c,
    output logic               valid_c
);

    // Scan NUM_REQ positions starting just past the last winner
    always_comb begin
        logic        found;
        int unsigned cand;
        found        = 1'b0;
        cand         = 0;
        grant_next_c = '0;
        idx_c        = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (32'(rr_ptr) + k + 32'd1) % NUM_REQ;
            if (!found && req[cand]) begin
                found              = 1'b1;
                idx_c              = IDX_W'(cand);
                grant_next_c[cand] = 1'b1;
            end
        end
        valid_c = found;
    end

endmodule : rr_arbiter

// File: rtl/cmp_sched.sv
// Round-robin scheduler sharing one magnitude comparator between NUM_REQ requesters.
// Optional macro CMP_SCHED_COUNT_EN adds a saturating count of completed compares.
module cmp_sched
    import cmp_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF
) (
    input  logic        clk,
    input  logic        n_rst,
    cmp_sched_if.slave  bus
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    cmp_state_t          state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic                busy_q, busy_d;
    cmp_res_t            res_q, res_d;
    logic [IDX_W-1:0]    result_id_q, result_id_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    id_q, id_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;

    logic [NUM_REQ-1:0]  arb_grant_c;
    logic [IDX_W-1:0]    arb_idx_c;
    logic                arb_valid_c;
    cmp_res_t            cmp_res_c;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req          (bus.req),
        .rr_ptr       (rr_ptr_q),
        .grant_next_c (arb_grant_c),
        .idx_c        (arb_idx_c),
        .valid_c      (arb_valid_c)
    );

    mag_cmp #(
        .W (DATA_W)
    ) u_cmp (
        .a     (a_q),
        .b     (b_q),
        .res_c (cmp_res_c)
    );

    // Next-state: IDLE grants and latches operands, CMP publishes the result
    always_comb begin
        state_d     = state_q;
        grant_d     = '0;
        done_d      = '0;
        busy_d      = 1'b0;
        res_d       = res_q;
        result_id_d = result_id_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        unique case (state_q)
            IDLE: begin
                if (arb_valid_c) begin
                    grant_d  = arb_grant_c;
                    a_d      = bus.a_in[32'(arb_idx_c) * DATA_W +: DATA_W];
                    b_d      = bus.b_in[32'(arb_idx_c) * DATA_W +: DATA_W];
                    id_d     = arb_idx_c;
                    rr_ptr_d = arb_idx_c;
                    busy_d   = 1'b1;
                    state_d  = CMP;
                end
            end
            CMP: begin
                res_d       = cmp_res_c;
                result_id_d = id_q;
                done_d      = NUM_REQ'(1) << id_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            done_q      <= '0;
            busy_q      <= 1'b0;
            res_q       <= '0;
            result_id_q <= '0;
            rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            res_q       <= res_d;
            result_id_q <= result_id_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            a_q         <= a_d;
            b_q         <= b_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign bus.gt        = res_q.gt;
    assign bus.lt        = res_q.lt;
    assign bus.eq        = res_q.eq;
    assign bus.result_id = result_id_q;

`ifdef CMP_SCHED_COUNT_EN
    logic [15:0] count_q, count_d;

    // Saturating count of edges where a done pulse is out
    always_comb begin
        count_d = count_q;
        if ((|done_q) && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.cmp_count = count_q;
`endif

endmodule : cmp_sched

// File: tb/tb_cmp_sched.sv
// Directed self-checking bench for cmp_sched (NUM_REQ=4, DATA_W=16).
module tb_cmp_sched;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 16;

    logic clk;
    logic n_rst;
    int   passed;
    int   total;

    cmp_sched_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

    cmp_sched #(
        .NUM_REQ (NR),
        .DATA_W  (DW)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int lane, input logic [15:0] a, input logic [15:0] b);
        bus.a_in[lane*16 +: 16] = a;
        bus.b_in[lane*16 +: 16] = b;
    endtask

    task automatic apply_reset();
        n_rst   = 1'b0;
        bus.req = '0;
        tick();
        tick();
        n_rst = 1'b1;
    endtask

    task automatic test_reset();
        n_rst    = 1'b0;
        bus.req  = 4'b1111;
        bus.a_in = '0;
        bus.b_in = '0;
        tick();
        tick();
        total++;
        if ({bus.grant, bus.done, bus.busy} !== 9'b0) $display("FAIL reset_ctl got grant=%b done=%b busy=%b want 0", bus.grant, bus.done, bus.busy);
        else passed++;
        total++;
        if ({bus.gt, bus.lt, bus.eq, bus.result_id} !== 5'b0) $display("FAIL reset_res got gt/lt/eq=%b%b%b id=%0d want 0", bus.gt, bus.lt, bus.eq, bus.result_id);
        else passed++;
        n_rst = 1'b1;
        tick();
        total++;
        if (bus.grant !== 4'b0001 || bus.busy !== 1'b1) $display("FAIL reset_first_grant got grant=%b busy=%b want 0001/1", bus.grant, bus.busy);
        else passed++;
        bus.req = '0;
        tick();
        total++;
        if (bus.done !== 4'b0001 || {bus.gt, bus.lt, bus.eq} !== 3'b001) $display("FAIL reset_first_done got done=%b res=%b%b%b want 0001/001", bus.done, bus.gt, bus.lt, bus.eq);
        else passed++;
    endtask

    task automatic test_single();
        set_lane(2, 16'h8000, 16'h7FFF);
        bus.req = 4'b0100;
        tick();
        total++;
        if (bus.grant !== 4'b0100) $display("FAIL single_grant got %b want 0100", bus.grant);
        else passed++;
        bus.req = '0;
        tick();
        total++;
        if (bus.done !== 4'b0100 || {bus.gt, bus.lt, bus.eq} !== 3'b100 || bus.result_id !== 2'd2 || bus.busy !== 1'b0)
            $display("FAIL single_done got done=%b res=%b%b%b id=%0d busy=%b want 0100/100/2/0", bus.done, bus.gt, bus.lt, bus.eq, bus.result_id, bus.busy);
        else passed++;
        tick();
        total++;
        if (bus.done !== 4'b0000 || {bus.gt, bus.lt, bus.eq} !== 3'b100) $display("FAIL single_hold got done=%b res=%b%b%b want 0000/100", bus.done, bus.gt, bus.lt, bus.eq);
        else passed++;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        logic [2:0] exp_r;
        logic [2:0] lane_res [4];
        lane_res[0] = 3'b010;
        lane_res[1] = 3'b010;
        lane_res[2] = 3'b001;
        lane_res[3] = 3'b100;
        apply_reset();
        for (int i = 0; i < 4; i++) set_lane(i, 16'(i), 16'd2);
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            exp_r = lane_res[k % 4];
            tick();
            total++;
            if (bus.grant !== exp_g || bus.busy !== 1'b1) $display("FAIL rr_grant%0d got %b busy=%b want %b", k, bus.grant, bus.busy, exp_g);
            else passed++;
            tick();
            total++;
            if (bus.done !== exp_g || bus.grant !== 4'b0 || {bus.gt, bus.lt, bus.eq} !== exp_r || bus.result_id !== 2'(k % 4))
                $display("FAIL rr_done%0d got done=%b grant=%b res=%b%b%b id=%0d want %b/0000/%b/%0d",
                         k, bus.done, bus.grant, bus.gt, bus.lt, bus.eq, bus.result_id, exp_g, exp_r, k % 4);
            else passed++;
        end
        bus.req = '0;
`ifdef CMP_SCHED_COUNT_EN
        tick();
        total++;
        if (bus.cmp_count !== 16'd5) $display("FAIL rr_count got %0d want 5", bus.cmp_count);
        else passed++;
`endif
    endtask

    task automatic test_boundary();
        logic [15:0] va [3];
        logic [15:0] vb [3];
        logic [2:0]  vr [3];
        va[0] = 16'h0000; vb[0] = 16'hFFFF; vr[0] = 3'b010;
        va[1] = 16'hFFFF; vb[1] = 16'hFFFF; vr[1] = 3'b001;
        va[2] = 16'hFFFF; vb[2] = 16'h0000; vr[2] = 3'b100;
        for (int k = 0; k < 3; k++) begin
            set_lane(1, va[k], vb[k]);
            bus.req = 4'b0010;
            tick();
            bus.req = '0;
            tick();
            total++;
            if (bus.done !== 4'b0010 || {bus.gt, bus.lt, bus.eq} !== vr[k])
                $display("FAIL boundary%0d got done=%b res=%b%b%b want 0010/%b", k, bus.done, bus.gt, bus.lt, bus.eq, vr[k]);
            else passed++;
        end
    endtask

    task automatic test_operand_change();
        set_lane(0, 16'd5, 16'd9);
        bus.req = 4'b0001;
        tick();
        total++;
        if (bus.grant !== 4'b0001) $display("FAIL opchg_grant got %b want 0001", bus.grant);
        else passed++;
        set_lane(0, 16'd20, 16'd9);
        bus.req = '0;
        tick();
        total++;
        if (bus.done !== 4'b0001 || {bus.gt, bus.lt, bus.eq} !== 3'b010 || bus.result_id !== 2'd0)
            $display("FAIL opchg_result got done=%b res=%b%b%b id=%0d want 0001/010/0", bus.done, bus.gt, bus.lt, bus.eq, bus.result_id);
        else passed++;
    endtask

    task automatic test_reset_mid();
        set_lane(0, 16'd7, 16'd7);
        set_lane(1, 16'd1, 16'd3);
        bus.req = 4'b0001;
        tick();
        total++;
        if (bus.grant !== 4'b0001) $display("FAIL midrst_grant got %b want 0001", bus.grant);
        else passed++;
        n_rst   = 1'b0;
        bus.req = '0;
        tick();
        total++;
        if ({bus.grant, bus.done, bus.busy, bus.gt, bus.lt, bus.eq, bus.result_id} !== 14'b0)
            $display("FAIL midrst_clear got grant=%b done=%b busy=%b res=%b%b%b id=%0d want all 0",
                     bus.grant, bus.done, bus.busy, bus.gt, bus.lt, bus.eq, bus.result_id);
        else passed++;
        n_rst   = 1'b1;
        bus.req = 4'b0010;
        tick();
        total++;
        if (bus.grant !== 4'b0010) $display("FAIL midrst_regrant got %b want 0010", bus.grant);
        else passed++;
        bus.req = '0;
        tick();
        total++;
        if (bus.done !== 4'b0010 || {bus.gt, bus.lt, bus.eq} !== 3'b010 || bus.result_id !== 2'd1)
            $display("FAIL midrst_done got done=%b res=%b%b%b id=%0d want 0010/010/1", bus.done, bus.gt, bus.lt, bus.eq, bus.result_id);
        else passed++;
    endtask

    task automatic test_back_to_back();
        set_lane(3, 16'h1234, 16'h1233);
        bus.req = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (bus.grant !== 4'b1000 || bus.done !== 4'b0000) $display("FAIL b2b_grant%0d got grant=%b done=%b want 1000/0000", k, bus.grant, bus.done);
            else passed++;
            tick();
            total++;
            if (bus.done !== 4'b1000 || bus.grant !== 4'b0000 || {bus.gt, bus.lt, bus.eq} !== 3'b100)
                $display("FAIL b2b_done%0d got done=%b grant=%b res=%b%b%b want 1000/0000/100", k, bus.done, bus.grant, bus.gt, bus.lt, bus.eq);
            else passed++;
        end
        bus.req = '0;
        tick();
        tick();
        total++;
        if (bus.busy !== 1'b0 || bus.grant !== 4'b0000) $display("FAIL b2b_idle got busy=%b grant=%b want 0/0000", bus.busy, bus.grant);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_boundary();
        test_operand_change();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_cmp_sched
